fb_scanout: RTL and testbench



---
 rtl/fb_scanout_pkg.sv | 37 +++
 rtl/fb_scanout_raster_counter.sv | 103 ++++++++++
 rtl/fb_scanout.sv | 116 +++++++++++
 tb/tb_fb_scanout.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_scanout_pkg.sv
// Shared types and helpers for the double-buffered framebuffer scan-out.
package fb_scanout_pkg;

    // Raster flags registered together on every pixel enable.
    typedef struct packed {
        logic hblank;
        logic vblank;
        logic hsync;
        logic vsync;
        logic active;
    } raster_flags_t;

    // Flag state while in reset: both blanks high, syncs and active area low.
    localparam raster_flags_t FLAGS_RESET = '{
        hblank: 1'b1,
        vblank: 1'b1,
        hsync:  1'b0,
        vsync:  1'b0,
        active: 1'b0
    };

    // Words in one buffer.
    function automatic int calc_bufsize(input int w, input int h);
        return w * h;
    endfunction

    // Address width covering both buffers.
    function automatic int calc_aw(input int w, input int h);
        return $clog2(2 * w * h);
    endfunction

    // True while cnt lies in [start, start+len); used for both sync pulses.
    function automatic logic in_window(input int cnt, input int start, input int len);
        return (cnt >= start) && (cnt < start + len);
    endfunction

endpackage

// File: rtl/fb_scanout_raster_counter.sv
// Raster timing: h/v counters, registered blank/sync/active flags, frame wrap
// strobe and an incrementally advanced read address (no read-side multiplier).
module raster_counter
    import fb_scanout_pkg::*;
#(
    parameter int WIDTH    = 288,
    parameter int HEIGHT   = 224,
    parameter int HTOTAL   = 384,
    parameter int VTOTAL   = 264,
    parameter int HS_START = 304,
    parameter int HS_LEN   = 32,
    parameter int VS_START = 240,
    parameter int VS_LEN   = 3,
    parameter int AW       = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic [AW-1:0] base_next,
    output logic          frame_wrap,
    output logic          rd_active,
    output logic [AW-1:0] rd_addr,
    output raster_flags_t flags,
    output logic          frame_start
);

    localparam int HW = $clog2(HTOTAL);
    localparam int VW = $clog2(VTOTAL);

    logic [HW-1:0] hcnt_r;
    logic [VW-1:0] vcnt_r;
    logic [AW-1:0] row_base_r;
    raster_flags_t flags_r;
    raster_flags_t flags_s;
    logic          frame_start_r;
    logic          line_end_s;
    logic          frame_wrap_s;

    assign line_end_s   = ce_pix && (hcnt_r == HW'(HTOTAL - 1));
    assign frame_wrap_s = line_end_s && (vcnt_r == VW'(VTOTAL - 1));

    // Flags for the current counter sample, before registering.
    always_comb begin
        flags_s        = FLAGS_RESET;
        flags_s.hblank = int'(hcnt_r) >= WIDTH;
        flags_s.vblank = int'(vcnt_r) >= HEIGHT;
        flags_s.hsync  = in_window(int'(hcnt_r), HS_START, HS_LEN);
        flags_s.vsync  = in_window(int'(vcnt_r), VS_START, VS_LEN);
        flags_s.active = (int'(hcnt_r) < WIDTH) && (int'(vcnt_r) < HEIGHT);
    end

    // Horizontal and vertical position, advancing only on pixel enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_r <= '0;
            vcnt_r <= '0;
        end else if (ce_pix) begin
            if (line_end_s) begin
                hcnt_r <= '0;
                vcnt_r <= frame_wrap_s ? '0 : vcnt_r + VW'(1);
            end else begin
                hcnt_r <= hcnt_r + HW'(1);
            end
        end
    end

    // Row base: jumps to the (possibly new) front buffer at frame wrap, else
    // steps one line per active row; it parks on the last row during vblank.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_base_r <= '0;
        end else if (frame_wrap_s) begin
            row_base_r <= base_next;
        end else if (line_end_s && (int'(vcnt_r) < HEIGHT - 1)) begin
            row_base_r <= row_base_r + AW'(WIDTH);
        end
    end

    // Flags share the one-enable latency of the RAM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r <= FLAGS_RESET;
        end else if (ce_pix) begin
            flags_r <= flags_s;
        end
    end

    // Single-clk pulse after the enable that sampled (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= ce_pix && (hcnt_r == '0) && (vcnt_r == '0);
        end
    end

    assign frame_wrap  = frame_wrap_s;
    assign rd_active   = flags_s.active;
    assign rd_addr     = row_base_r + AW'(hcnt_r);
    assign flags       = flags_r;
    assign frame_start = frame_start_r;

endmodule

// File: rtl/fb_scanout.sv
// Double-buffered framebuffer: the core writes the back buffer by (x,y), the
// raster reads the front buffer, and a requested swap lands at frame wrap.
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter int WIDTH    = 288,
    parameter int HEIGHT   = 224,
    parameter int DEPTH    = 8,
    parameter int HTOTAL   = 384,
    parameter int VTOTAL   = 264,
    parameter int HS_START = 304,
    parameter int HS_LEN   = 32,
    parameter int VS_START = 240,
    parameter int VS_LEN   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ce_pix,
    input  logic                       wr_en,
    input  logic [$clog2(WIDTH)-1:0]   wr_x,
    input  logic [$clog2(HEIGHT)-1:0]  wr_y,
    input  logic [DEPTH-1:0]           wr_data,
    input  logic                       frame_done,
    output logic                       swap_pending,
    output logic                       front_buf,
    output logic [DEPTH-1:0]           video_out,
    output logic                       hblank,
    output logic                       vblank,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       frame_start
);

    localparam int BUFSIZE = calc_bufsize(WIDTH, HEIGHT);
    localparam int AW      = calc_aw(WIDTH, HEIGHT);

    logic [DEPTH-1:0] mem_r [0:2*BUFSIZE-1];
    logic [DEPTH-1:0] ram_q_r;
    logic             front_buf_r;
    logic             swap_pending_r;
    logic             swap_now_s;
    logic             frame_wrap_s;
    logic             rd_active_s;
    logic [AW-1:0]    rd_addr_s;
    logic [AW-1:0]    base_next_s;
    logic [AW-1:0]    wr_addr_s;
    logic             wr_ok_s;
    raster_flags_t    flags_s;

    raster_counter #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .HTOTAL  (HTOTAL),
        .VTOTAL  (VTOTAL),
        .HS_START(HS_START),
        .HS_LEN  (HS_LEN),
        .VS_START(VS_START),
        .VS_LEN  (VS_LEN),
        .AW      (AW)
    ) u_raster (
        .clk        (clk),
        .reset      (reset),
        .ce_pix     (ce_pix),
        .base_next  (base_next_s),
        .frame_wrap (frame_wrap_s),
        .rd_active  (rd_active_s),
        .rd_addr    (rd_addr_s),
        .flags      (flags_s),
        .frame_start(frame_start)
    );

    // Swap lands at the wrap enable; a request on that same clk still counts.
    assign swap_now_s  = frame_wrap_s && (swap_pending_r || frame_done);
    assign base_next_s = (front_buf_r ^ swap_now_s) ? AW'(BUFSIZE) : '0;

    // Back buffer is the non-displayed one, judged by the pre-swap front index.
    assign wr_ok_s   = wr_en && (int'(wr_x) < WIDTH) && (int'(wr_y) < HEIGHT);
    assign wr_addr_s = (front_buf_r ? '0 : AW'(BUFSIZE))
                     + AW'(wr_y) * AW'(WIDTH) + AW'(wr_x);

    // Write port; out-of-range coordinates are dropped.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_addr_s] <= wr_data;
        end
    end

    // Registered read port; only active samples touch the array.
    always_ff @(posedge clk) begin
        if (ce_pix && rd_active_s) begin
            ram_q_r <= mem_r[rd_addr_s];
        end
    end

    // Front index and swap request; reset discards any pending request.
    always_ff @(posedge clk) begin
        if (reset) begin
            front_buf_r    <= 1'b0;
            swap_pending_r <= 1'b0;
        end else if (swap_now_s) begin
            front_buf_r    <= ~front_buf_r;
            swap_pending_r <= 1'b0;
        end else if (frame_done) begin
            swap_pending_r <= 1'b1;
        end
    end

    assign video_out    = flags_s.active ? ram_q_r : '0;
    assign hblank       = flags_s.hblank;
    assign vblank       = flags_s.vblank;
    assign hsync        = flags_s.hsync;
    assign vsync        = flags_s.vsync;
    assign front_buf    = front_buf_r;
    assign swap_pending = swap_pending_r;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout on a reduced raster so whole frames stay short.
module tb_fb_scanout;

    localparam int W   = 12;
    localparam int H   = 9;
    localparam int DP  = 8;
    localparam int HT  = 16;
    localparam int VT  = 12;
    localparam int HSS = 13;
    localparam int HSL = 2;
    localparam int VSS = 10;
    localparam int VSL = 1;
    localparam int XW  = $clog2(W);
    localparam int YW  = $clog2(H);
    localparam int FRAME = HT * VT;

    logic          clk = 1'b0;
    logic          reset, ce_pix, wr_en, frame_done;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [DP-1:0] wr_data;
    logic          swap_pending, front_buf, hblank, vblank, hsync, vsync, frame_start;
    logic [DP-1:0] video_out;

    always #5 clk = ~clk;

    fb_scanout #(
        .WIDTH(W), .HEIGHT(H), .DEPTH(DP), .HTOTAL(HT), .VTOTAL(VT),
        .HS_START(HSS), .HS_LEN(HSL), .VS_START(VSS), .VS_LEN(VSL)
    ) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .wr_en(wr_en),
        .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .frame_done(frame_done),
        .swap_pending(swap_pending), .front_buf(front_buf), .video_out(video_out),
        .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: beam position, buffer contents as 2-D pictures.
    int            m_h, m_v;
    bit            m_front, m_pending;
    logic [DP-1:0] fb [2][H][W];
    bit            known [2][H][W];
    logic [DP-1:0] e_video;
    bit            e_vknown, e_hb, e_vb, e_hs, e_vs, e_fs;
    int            s_x, s_y;
    bit            chk57 = 1'b0;
    int            fs_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("front_buf",    32'(front_buf),    32'(m_front));
        chk("swap_pending", 32'(swap_pending), 32'(m_pending));
        chk("hblank",       32'(hblank),       32'(e_hb));
        chk("vblank",       32'(vblank),       32'(e_vb));
        chk("hsync",        32'(hsync),        32'(e_hs));
        chk("vsync",        32'(vsync),        32'(e_vs));
        chk("frame_start",  32'(frame_start),  32'(e_fs));
        if (e_vknown) chk("video_out", 32'(video_out), 32'(e_video));
    endtask

    task automatic model_reset();
        m_h = 0; m_v = 0; m_front = 1'b0; m_pending = 1'b0;
        e_video = '0; e_vknown = 1'b1;
        e_hb = 1'b1; e_vb = 1'b1; e_hs = 1'b0; e_vs = 1'b0; e_fs = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1; ce_pix = 1'b1; wr_en = 1'b0; frame_done = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            model_reset();
            #1;
            check_all();
        end
        reset = 1'b0;
    endtask

    // One clk of stimulus, model update at the edge, then check all outputs.
    task automatic step(input bit ce, input bit we, input int x, input int y,
                        input int d, input bit fd);
        bit wrap;
        bit act;
        bit sampled;
        ce_pix = ce; wr_en = we; wr_x = XW'(x); wr_y = YW'(y);
        wr_data = DP'(d); frame_done = fd;
        @(posedge clk);
        wrap = 1'b0; sampled = 1'b0; e_fs = 1'b0;
        if (ce) begin
            sampled = 1'b1; s_x = m_h; s_y = m_v;
            e_hb = (m_h >= W);
            e_vb = (m_v >= H);
            e_hs = (m_h >= HSS) && (m_h < HSS + HSL);
            e_vs = (m_v >= VSS) && (m_v < VSS + VSL);
            act  = !e_hb && !e_vb;
            if (act) begin
                e_video  = fb[m_front][m_v][m_h];
                e_vknown = known[m_front][m_v][m_h];
            end else begin
                e_video  = '0;
                e_vknown = 1'b1;
            end
            e_fs = (m_h == 0) && (m_v == 0);
            wrap = (m_h == HT - 1) && (m_v == VT - 1);
            m_h++;
            if (m_h == HT) begin
                m_h = 0;
                m_v = (m_v + 1) % VT;
            end
        end
        if (we && x < W && y < H) begin
            fb[~m_front][y][x]    = DP'(d);
            known[~m_front][y][x] = 1'b1;
        end
        if (wrap && (m_pending || fd)) begin
            m_front   = ~m_front;
            m_pending = 1'b0;
        end else if (fd) begin
            m_pending = 1'b1;
        end
        #1;
        check_all();
        if (frame_start) fs_seen++;
        if (chk57 && sampled && s_x == 5 && s_y == 7) chk("pix_5_7", 32'(video_out), 32'h02);
        wr_en = 1'b0; frame_done = 1'b0;
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    known[b][y][x] = 1'b0;
                    fb[b][y][x]    = '0;
                end
        reset = 1'b0; ce_pix = 1'b0; wr_en = 1'b0; frame_done = 1'b0;
        wr_x = '0; wr_y = '0; wr_data = '0;

        // Reset state, then one full frame of timing with no writes.
        do_reset(2);
        fs_seen = 0;
        for (int i = 0; i < FRAME; i++) step(1'b1, 1'b0, 0, 0, 0, 1'b0);
        chk("frame_start_count", 32'(fs_seen), 32'd1);

        // x^y into buffer 1 while scanning, swap requested mid-frame.
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) step(1'b1, 1'b1, x, y, x ^ y, 1'b0);
        step(1'b1, 1'b0, 0, 0, 0, 1'b1);
        chk("pending_after_done", 32'(swap_pending), 32'd1);
        for (int k = 0; k < FRAME && !(m_h == 0 && m_v == 0); k++) step(1'b1, 1'b0, 0, 0, 0, 1'b0);
        chk("front_after_swap", 32'(front_buf), 32'd1);
        chk57 = 1'b1;
        for (int i = 0; i < FRAME; i++) step(1'b1, 1'b0, 0, 0, 0, 1'b0);
        chk57 = 1'b0;

        // Random fill of buffer 0 with random pixel enables.
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                step(1'($urandom_range(0, 1)), 1'b1, x, y, int'($urandom_range(0, 255)), 1'b0);

        // Out-of-range writes must vanish (buffer 0 is shown next frame).
        step(1'b1, 1'b1, W, 0, 8'hAA, 1'b0);
        step(1'b1, 1'b1, W, H - 1, 8'hAB, 1'b0);
        step(1'b1, 1'b1, 0, H, 8'h55, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1)
                step(1'b1, 1'b1, int'($urandom_range(W, 2**XW - 1)), int'($urandom_range(0, H - 1)),
                     int'($urandom_range(0, 255)), 1'b0);
            else
                step(1'b1, 1'b1, int'($urandom_range(0, W - 1)), int'($urandom_range(H, 2**YW - 1)),
                     int'($urandom_range(0, 255)), 1'b0);
        end

        // Request exactly on the wrap enable, then twice more in one frame.
        for (int k = 0; k < FRAME && !(m_h == HT - 1 && m_v == VT - 1); k++)
            step(1'b1, 1'b0, 0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 0, 1'b1);
        chk("front_wrap_request", 32'(front_buf), 32'd0);
        chk("pending_wrap_request", 32'(swap_pending), 32'd0);
        for (int i = 0; i < FRAME; i++) step(1'b1, 1'b0, 0, 0, 0, (i == 20) || (i == 50));
        chk("front_double_request", 32'(front_buf), 32'd1);
        chk("pending_double_request", 32'(swap_pending), 32'd0);

        // Pixel enable every 4th clk: outputs must hold between enables.
        fs_seen = 0;
        for (int i = 0; i < 4 * FRAME; i++) step((i % 4) == 0, 1'b0, 0, 0, 0, 1'b0);
        chk("frame_start_count_ce4", 32'(fs_seen), 32'd1);

        // Mid-frame reset with a pending swap.
        for (int k = 0; k < FRAME && m_v != 5; k++) step(1'b1, 1'b0, 0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 0, 1'b1);
        chk("pending_before_reset", 32'(swap_pending), 32'd1);
        do_reset(1);
        step(1'b1, 1'b0, 0, 0, 0, 1'b0);
        chk("post_reset_pix00", 32'(video_out), 32'(fb[0][0][0]));
        for (int i = 0; i < W + 4; i++) step(1'b1, 1'b0, 0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
